// File: rtl/mips_cpu_pkg.sv
// Shared register-file constants and types for the MIPS write-back path.
package mips_cpu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/mips_cpu_regfile_wb_arbiter_if.sv
// Write-back requester bus, register-file write port and forward-compare signals.
interface mips_cpu_regfile_wb_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    wb_hold;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic [ADDR_W-1:0]       rd_addr_a;
  logic [ADDR_W-1:0]       rd_addr_b;
  logic                    fwd_hit_a;
  logic                    fwd_hit_b;
  logic                    busy;

  modport master (
    output req_valid, req_addr, req_data, wb_hold, rd_addr_a, rd_addr_b,
    input  req_ready, wr_en, wr_addr, wr_data, fwd_hit_a, fwd_hit_b, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data, wb_hold, rd_addr_a, rd_addr_b,
    output req_ready, wr_en, wr_addr, wr_data, fwd_hit_a, fwd_hit_b, busy
  );
endinterface

// File: rtl/mips_cpu_rr_arbiter.sv
// Round-robin arbiter: scans from ptr upward with wrap, one-hot grant, ptr moves past winner.
module mips_cpu_rr_arbiter #(
  parameter int  N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] win,
  output logic          gnt_any
);
  logic [IW-1:0] ptr;

  // Scan offsets high to low so the lowest offset from ptr is the last writer.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    win     = '0;
    gnt_any = 1'b0;
    if (en) begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        if (req[idx]) begin
          win     = IW'(idx);
          gnt_any = 1'b1;
        end
      end
    end
    if (gnt_any) gnt[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     ptr <= '0;
    else if (gnt_any) ptr <= (int'(win) == N - 1) ? '0 : win + 1'b1;
  end
endmodule

// File: rtl/mips_cpu_regfile_wb_arbiter.sv
// Shares the register file write port among N write-back sources: round-robin grant,
// one registered write stage, $zero discard and read-port forward-hit flags.
module mips_cpu_regfile_wb_arbiter
  import mips_cpu_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input logic                          clk,
  input logic                          reset_n,
  mips_cpu_regfile_wb_arbiter_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  gnt;
  logic [IW-1:0]     win;
  logic              gnt_any;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              win_nz;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  // Gating with reset_n keeps req_ready low for the whole reset window.
  mips_cpu_rr_arbiter #(.N(N_REQ)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (~bus.wb_hold & reset_n),
    .req     (bus.req_valid),
    .gnt     (gnt),
    .win     (win),
    .gnt_any (gnt_any)
  );

  assign bus.req_ready = gnt;
  assign win_addr      = bus.req_addr[win*ADDR_W +: ADDR_W];
  assign win_data      = bus.req_data[win*DATA_W +: DATA_W];
  assign win_nz        = (win_addr != ADDR_W'(ZERO_REG));

  // A $zero grant still consumes the request but never strobes the file.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= gnt_any & win_nz;
      if (gnt_any & win_nz) begin
        wr_addr_q <= win_addr;
        wr_data_q <= win_data;
      end
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.fwd_hit_a = wr_en_q & (wr_addr_q == bus.rd_addr_a) & (bus.rd_addr_a != ADDR_W'(ZERO_REG));
  assign bus.fwd_hit_b = wr_en_q & (wr_addr_q == bus.rd_addr_b) & (bus.rd_addr_b != ADDR_W'(ZERO_REG));
  assign bus.busy      = (|bus.req_valid) | wr_en_q;
endmodule

// File: tb/tb_mips_cpu_regfile_wb_arbiter.sv
// Bench for the write-back arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_mips_cpu_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mips_cpu_regfile_wb_arbiter_if #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

  mips_cpu_regfile_wb_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [N-1:0]    tv = '0;
  logic [N*AW-1:0] ta = '0;
  logic [N*DW-1:0] td = '0;
  logic            hold = 1'b0;
  logic [AW-1:0]   ra = '0, rb = '0;

  assign bus.req_valid = tv;
  assign bus.req_addr  = ta;
  assign bus.req_data  = td;
  assign bus.wb_hold   = hold;
  assign bus.rd_addr_a = ra;
  assign bus.rd_addr_b = rb;

  // Register file as mips_cpu_registers would see it.
  logic [DW-1:0] d_file [32] = '{default: '0};
  always @(posedge clk) if (bus.wr_en) d_file[bus.wr_addr] <= bus.wr_data;

  // Model: pending writes per requester, rr pointer, the write in flight, the file contents.
  wr_t           q [N][$];
  int            m_ptr = 0;
  bit            m_en = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] m_file [32] = '{default: '0};

  int n_chk = 0, n_pass = 0;
  logic [N-1:0]  s_ready;
  logic          s_wr_en, s_fa, s_fb;
  logic [AW-1:0] s_wr_addr;
  logic [DW-1:0] s_wr_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int exp_grant();
    int idx;
    if (hold || !reset_n) return -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (q[idx].size() > 0) return idx;
    end
    return -1;
  endfunction

  task automatic drive();
    tv = '0; ta = '0; td = '0;
    for (int i = 0; i < N; i++)
      if (q[i].size() > 0) begin
        tv[i] = 1'b1;
        ta[i*AW +: AW] = q[i][0].a;
        td[i*DW +: DW] = q[i][0].d;
      end
  endtask

  task automatic push(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.a = a; w.d = d;
    q[r].push_back(w);
  endtask

  // One clock: drive from queues, check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle(output int g);
    int eg;
    logic [N-1:0] er;
    wr_t h;
    drive();
    #1;
    eg = exp_grant();
    er = '0;
    if (eg >= 0) er[eg] = 1'b1;
    s_ready = bus.req_ready; s_wr_en = bus.wr_en; s_wr_addr = bus.wr_addr;
    s_wr_data = bus.wr_data; s_fa = bus.fwd_hit_a; s_fb = bus.fwd_hit_b;
    chk("ready", s_ready, er);
    chk("wr_en", s_wr_en, m_en);
    if (m_en) begin
      chk("wr_addr", s_wr_addr, m_addr);
      chk("wr_data", s_wr_data, m_data);
    end
    chk("fwd_a", s_fa, m_en && m_addr == ra && ra != 0);
    chk("fwd_b", s_fb, m_en && m_addr == rb && rb != 0);
    chk("busy", bus.busy, (tv != 0) || m_en);
    @(posedge clk);
    if (m_en) m_file[m_addr] = m_data;
    if (eg >= 0) begin
      h = q[eg].pop_front();
      m_ptr = (eg + 1) % N;
      m_en = (h.a != 0);
      if (m_en) begin m_addr = h.a; m_data = h.d; end
    end else m_en = 0;
    g = eg;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m_en = 0; m_addr = '0; m_data = '0; m_ptr = 0;
    drive();
    #1;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    for (int i = 0; i < N; i++) q[i].delete();
    drive();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int g;
    @(negedge clk);
    do_reset();

    // Reset in the middle of a write, then req0 wins from ptr 0.
    push(0, 5'd9, 32'h99); push(1, 5'd10, 32'hAA);
    cycle(g);
    chk("t1_g", g, 0);
    push(0, 5'd11, 32'hBB);
    do_reset();
    push(0, 5'd12, 32'h1); push(1, 5'd13, 32'h2);
    cycle(g);
    chk("t1_after_g", g, 0);
    chk("t1_after_ready", s_ready, 3'b001);
    do_reset();

    // Round robin over three requesters.
    push(0, 5'd1, 32'hA); push(1, 5'd2, 32'hB); push(2, 5'd3, 32'hC); push(0, 5'd4, 32'hD);
    cycle(g); chk("t2_g0", g, 0); chk("t2_en0", s_wr_en, 0);
    cycle(g); chk("t2_g1", g, 1); chk("t2_addr1", s_wr_addr, 1);
    cycle(g); chk("t2_g2", g, 2); chk("t2_addr2", s_wr_addr, 2);
    cycle(g); chk("t2_g3", g, 0); chk("t2_addr3", s_wr_addr, 3); chk("t2_en3", s_wr_en, 1);
    cycle(g); chk("t2_data4", s_wr_data, 32'hD);
    do_reset();

    // $zero destination consumes the request without a write.
    push(0, 5'd6, 32'h6);
    cycle(g);
    push(1, 5'd0, 32'hDEADBEEF); ra = '0;
    cycle(g); chk("t3_g", g, 1); chk("t3_ready", s_ready, 3'b010);
    push(1, 5'd12, 32'h12); push(2, 5'd13, 32'h13);
    cycle(g); chk("t3_en", s_wr_en, 0); chk("t3_fwd", s_fa, 0); chk("t3_ptr", g, 2);
    do_reset();

    // Hold freezes grants; the registered write still drains.
    push(0, 5'd1, 32'h1); push(1, 5'd2, 32'h2); push(2, 5'd3, 32'h3);
    cycle(g);
    hold = 1'b1;
    cycle(g); chk("t4_drain_en", s_wr_en, 1); chk("t4_ready", s_ready, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(g); chk("t4_hold_en", s_wr_en, 0);
    end
    hold = 1'b0;
    cycle(g); chk("t4_resume", g, 1);
    cycle(g); cycle(g);
    do_reset();

    // Forwarding hit on port A only.
    push(2, 5'd7, 32'h12345678); ra = 5'd7; rb = 5'd8;
    cycle(g); chk("t5_g", g, 2);
    cycle(g); chk("t5_fa", s_fa, 1); chk("t5_fb", s_fb, 0); chk("t5_data", s_wr_data, 32'h12345678);
    do_reset();

    // Same destination: grant order decides the survivor.
    push(0, 5'd5, 32'h1); push(1, 5'd5, 32'h2);
    for (int i = 0; i < 4; i++) cycle(g);
    chk("t6_file", d_file[5], 32'h2);
    chk("t6_model", m_file[5], 32'h2);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      hold = ($urandom_range(9) == 0);
      ra = AW'($urandom_range(7));
      rb = AW'($urandom_range(7));
      for (int i = 0; i < N; i++)
        if (q[i].size() < 3 && $urandom_range(2) == 0)
          push(i, AW'($urandom_range(7)), $urandom);
      if ($urandom_range(499) == 0) do_reset();
      else cycle(g);
    end
    hold = 1'b0;
    for (int i = 0; i < 12; i++) cycle(g);
    for (int r = 0; r < 32; r++) chk($sformatf("file_r%0d", r), d_file[r], m_file[r]);
    chk("file_r0_zero", d_file[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
